// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring divide, 35-cycle latency (2 on fast path or forward hit).
// Accepts only while idle_o=1; requests while busy are ignored. Optional result store: DIV_RESULT_FORWARD_EN.
module iterative_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            data_valid_i,
    input  logic [1:0]      operation_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            idle_o,
    output logic            data_valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREPARE  = 2'd1,
        DIVIDE   = 2'd2,
        FINALIZE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic            r_idle;
    logic            r_valid;
    logic [XLEN-1:0] r_result;
    logic [1:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_dvs;
    logic [XLEN-1:0] r_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [5:0]      r_cnt;

`ifdef DIV_RESULT_FORWARD_EN
    logic            r_fwd_vld;
    logic [XLEN-1:0] r_fwd_a;
    logic [XLEN-1:0] r_fwd_b;
    logic            r_fwd_sgn;
    logic [XLEN-1:0] r_fwd_q;
    logic [XLEN-1:0] r_fwd_r;
`endif

    logic            w_signed;
    logic            w_fast_hit;
    logic [XLEN-1:0] w_fast_q;
    logic [XLEN-1:0] w_fast_r;
    logic            w_op_signed;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN:0]   w_shift;
    logic            w_qbit;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;

    assign w_signed = ~operation_i[0];

    // Results that need no iteration are resolved here so FINALIZE sees them as unsigned, unnegated values.
    always_comb begin
        w_fast_hit = 1'b0;
        w_fast_q   = '0;
        w_fast_r   = '0;
        if (divisor_i == '0) begin
            w_fast_hit = 1'b1;
            w_fast_q   = '1;
            w_fast_r   = dividend_i;
        end else if (w_signed && (dividend_i == INT_MIN) && (divisor_i == '1)) begin
            w_fast_hit = 1'b1;
            w_fast_q   = INT_MIN;
            w_fast_r   = '0;
        end
`ifdef DIV_RESULT_FORWARD_EN
        if (r_fwd_vld && (r_fwd_a == dividend_i) && (r_fwd_b == divisor_i) && (r_fwd_sgn == w_signed)) begin
            w_fast_hit = 1'b1;
            w_fast_q   = r_fwd_q;
            w_fast_r   = r_fwd_r;
        end
`endif
    end

    assign w_op_signed = ~r_op[0];
    assign w_abs_a     = (w_op_signed && r_a[XLEN-1]) ? (~r_a + 1'b1) : r_a;
    assign w_abs_b     = (w_op_signed && r_b[XLEN-1]) ? (~r_b + 1'b1) : r_b;

    // Quotient bits shift into r_quot as dividend bits shift out of its top.
    assign w_shift = {r_rem, r_quot[XLEN-1]};
    assign w_qbit  = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

    assign w_q_fin = r_neg_q ? (~r_quot + 1'b1) : r_quot;
    assign w_r_fin = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_idle   <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_quot   <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
`ifdef DIV_RESULT_FORWARD_EN
            r_fwd_vld <= 1'b0;
            r_fwd_a   <= '0;
            r_fwd_b   <= '0;
            r_fwd_sgn <= 1'b0;
            r_fwd_q   <= '0;
            r_fwd_r   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (flush_i) begin
                r_state <= IDLE;
                r_idle  <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (data_valid_i) begin
                            r_op   <= operation_i;
                            r_a    <= dividend_i;
                            r_b    <= divisor_i;
                            r_idle <= 1'b0;
                            if (w_fast_hit) begin
                                r_quot  <= w_fast_q;
                                r_rem   <= w_fast_r;
                                r_neg_q <= 1'b0;
                                r_neg_r <= 1'b0;
                                r_state <= FINALIZE;
                            end else begin
                                r_state <= PREPARE;
                            end
                        end
                    end
                    PREPARE: begin
                        r_quot  <= w_abs_a;
                        r_dvs   <= w_abs_b;
                        r_rem   <= '0;
                        r_neg_q <= w_op_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);
                        r_neg_r <= w_op_signed && r_a[XLEN-1];
                        r_cnt   <= '0;
                        r_state <= DIVIDE;
                    end
                    DIVIDE: begin
                        r_rem  <= w_qbit ? w_diff : w_shift[XLEN-1:0];
                        r_quot <= {r_quot[XLEN-2:0], w_qbit};
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_state <= FINALIZE;
                        end
                    end
                    FINALIZE: begin
                        r_result <= r_op[1] ? w_r_fin : w_q_fin;
                        r_valid  <= 1'b1;
                        r_idle   <= 1'b1;
                        r_state  <= IDLE;
`ifdef DIV_RESULT_FORWARD_EN
                        r_fwd_vld <= 1'b1;
                        r_fwd_a   <= r_a;
                        r_fwd_b   <= r_b;
                        r_fwd_sgn <= w_op_signed;
                        r_fwd_q   <= w_q_fin;
                        r_fwd_r   <= w_r_fin;
`endif
                    end
                    default: begin
                        r_state <= IDLE;
                        r_idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign idle_o       = r_idle;
    assign data_valid_o = r_valid;
    assign result_o     = r_result;

endmodule

// File: tb/tb_iterative_divider.sv
// Directed scoreboard bench for iterative_divider: results and accept-to-valid latency per request.
module tb_iterative_divider;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

`ifdef DIV_RESULT_FORWARD_EN
    localparam int HIT_LAT = 2;
`else
    localparam int HIT_LAT = 35;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        data_valid_i;
    logic [1:0]  operation_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        idle_o;
    logic        data_valid_o;
    logic [31:0] result_o;

    typedef struct packed {
        logic [31:0] res;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   cnt_dv;
    int   cnt_busy;

    iterative_divider #(.XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .flush_i      (flush_i),
        .data_valid_i (data_valid_i),
        .operation_i  (operation_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .idle_o       (idle_o),
        .data_valid_o (data_valid_o),
        .result_o     (result_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = 8'(lat);
        sb_q.push_back(e);
    endtask

    // Drives one request at a negedge; acceptance happens on the following posedge.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input bit push);
        for (int i = 0; i < 100 && !idle_o; i++) @(negedge clk_i);
        if (!idle_o) check({tag, "_idle_wait"}, 32'(idle_o), 32'd1);
        data_valid_i = 1'b1;
        operation_i  = op;
        dividend_i   = a;
        divisor_i    = b;
        if (push) push_exp(res, lat);
    endtask

    task automatic collect(input string tag, input int start_lat, input int npulses);
        int   lat;
        int   seen;
        int   bad_idle;
        exp_t e;
        lat      = start_lat;
        seen     = 0;
        bad_idle = 0;
        while (seen < npulses && lat < 200) begin
            @(negedge clk_i);
            lat++;
            if (data_valid_i && !idle_o && seen == npulses - 1) data_valid_i = 1'b0;
            if (data_valid_o) begin
                seen++;
                check({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check({tag, "_res"}, result_o, e.res);
                    check({tag, "_lat"}, 32'(lat), 32'(e.lat));
                    check({tag, "_idle_at_pulse"}, 32'(idle_o), 32'd1);
                end
            end else if (idle_o) begin
                bad_idle++;
            end
        end
        if (seen < npulses) check({tag, "_pulses"}, 32'(seen), 32'(npulses));
        check({tag, "_busy_idle"}, 32'(bad_idle), 32'd0);
    endtask

    task automatic op_test(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input int lat);
        issue(tag, op, a, b, res, lat, 1'b1);
        collect(tag, 0, 1);
    endtask

    initial begin
        rst_n_i      = 1'b0;
        flush_i      = 1'b0;
        data_valid_i = 1'b0;
        operation_i  = 2'd0;
        dividend_i   = 32'd0;
        divisor_i    = 32'd0;
        repeat (2) @(negedge clk_i);
        check("reset_idle", 32'(idle_o), 32'd1);
        check("reset_valid", 32'(data_valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        op_test("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
        op_test("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, HIT_LAT);
        op_test("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35);
        op_test("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, HIT_LAT);
        op_test("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 35);
        op_test("rem_7_m2", OP_REM, 32'd7, 32'hFFFFFFFE, 32'd1, HIT_LAT);
        op_test("divu_big", OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1, 35);
        op_test("remu_big", OP_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, HIT_LAT);
        op_test("divu_max_3", OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, 35);
        op_test("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        op_test("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
        op_test("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 2);
        op_test("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 2);

        // Flush in the accept cycle must win: nothing starts.
        issue("flush_prio", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i      = 1'b0;
        data_valid_i = 1'b0;
        cnt_dv   = 0;
        cnt_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (data_valid_o) cnt_dv++;
            if (!idle_o) cnt_busy++;
        end
        check("flush_prio_pulses", 32'(cnt_dv), 32'd0);
        check("flush_prio_busy", 32'(cnt_busy), 32'd0);

        // Mid-operation flush at N+10, next request accepted at N+11.
        issue("flush_mid", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        cnt_dv = 0;
        for (int lat = 1; lat <= 11; lat++) begin
            @(negedge clk_i);
            if (lat == 1) data_valid_i = 1'b0;
            if (data_valid_o) cnt_dv++;
            if (lat == 10) flush_i = 1'b1;
            if (lat == 11) flush_i = 1'b0;
        end
        check("flush_mid_pulses", 32'(cnt_dv), 32'd0);
        check("flush_mid_idle", 32'(idle_o), 32'd1);
        check("flush_mid_result_kept", result_o, 32'd5);
        op_test("remu_9_4", OP_REMU, 32'd9, 32'd4, 32'd1, 35);

        // Second request held high while busy; accepted in the first pulse cycle.
        issue("b2b", OP_DIVU, 32'd1000, 32'd10, 32'd100, 35, 1'b1);
        @(negedge clk_i);
        operation_i = OP_DIV;
        dividend_i  = 32'hFFFFFC18;
        divisor_i   = 32'd10;
        push_exp(32'hFFFFFF9C, 70);
        collect("b2b", 1, 2);

        // Async reset at N+20 clears outputs immediately and suppresses the pulse.
        issue("rst_mid", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
        cnt_dv = 0;
        for (int lat = 1; lat <= 20; lat++) begin
            @(negedge clk_i);
            if (lat == 1) data_valid_i = 1'b0;
            if (data_valid_o) cnt_dv++;
        end
        check("hold_result", result_o, 32'hFFFFFF9C);
        rst_n_i = 1'b0;
        #1;
        check("rst_mid_idle", 32'(idle_o), 32'd1);
        check("rst_mid_valid", 32'(data_valid_o), 32'd0);
        check("rst_mid_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (data_valid_o) cnt_dv++;
        end
        check("rst_mid_pulses", 32'(cnt_dv), 32'd0);
        check("rst_mid_result_after", result_o, 32'd0);

        op_test("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 35);
        op_test("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2, HIT_LAT);
        op_test("divu_after_div", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Integer divide sub-unit of the ITU. Consumes a 2-bit divide uop (DIV=0, DIVU=1, REM=2, REMU=3) plus two 32-bit operands from the issue stage.
- Produces a 32-bit RV32M-compliant result using a radix-2 restoring algorithm, one quotient bit per cycle.
- Single outstanding operation. Accepts a new one only while idle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  kill in-flight operation (pipeline flush)
- data_valid_i  in  1  operation request
- operation_i  in  2  div uop: DIV=0, DIVU=1, REM=2, REMU=3
- dividend_i  in  XLEN  rs1
- divisor_i  in  XLEN  rs2
- idle_o  out  1  unit can accept a request this cycle
- data_valid_o  out  1  result valid, one-cycle pulse
- result_o  out  XLEN  quotient or remainder, per operation

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; idle_o=1; data_valid_o=0; result_o=0; all internal registers 0.
- Accept: a request is accepted on a clock edge where data_valid_i=1, idle_o=1 and flush_i=0. Call that cycle N. data_valid_i while busy is ignored; upstream holds the request until idle_o=1.
- FSM states: IDLE, PREPARE, DIVIDE, FINALIZE.
- IDLE -> PREPARE on accept; the uop and operands are registered.
- IDLE -> FINALIZE on accept for the special cases below (fast path).
- PREPARE (N+1): for DIV/REM, take the absolute value of each operand; record quotient sign = sign(a) XOR sign(b), and remainder sign = sign(a). Clear the 6-bit iteration counter.
- DIVIDE (N+2..N+33): 32 iterations. Each iteration:
  - partial remainder is shifted left 1 and takes the dividend MSB;
  - subtract the divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
  - Exit on counter = 31.
- FINALIZE (N+34): negate the quotient/remainder as recorded; select quotient (DIV/DIVU) or remainder (REM/REMU); register it into result_o.
- FINALIZE -> IDLE always. In the following cycle (N+35): data_valid_o=1 for exactly one cycle; idle_o=1, so a new accept is allowed in that same cycle.
- Normal latency: 35 cycles from accept to data_valid_o.
- Fast path (decided combinationally at accept; next state FINALIZE; data_valid_o at N+2):
  - divisor==0: quotient = 0xFFFFFFFF; remainder = dividend (signed and unsigned).
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- result_o holds its value until the next FINALIZE or reset.
- idle_o=0 in PREPARE, DIVIDE and FINALIZE.
- flush_i=1 in any state: next state IDLE, no data_valid_o pulse. flush_i has priority over a same-cycle accept. result_o is unchanged.
- Reset mid-operation: immediate return to reset values; no pulse.

Optional Feature:
- DIV_RESULT_FORWARD_EN defined:
  - On every normal or fast-path completion, store dividend, divisor, signedness (DIV/REM vs DIVU/REMU), final quotient and final remainder, and set a cache-valid bit. The valid bit is cleared by reset only; a flushed operation never updates the store.
  - An accepted request whose operands and signedness match a valid entry goes IDLE -> FINALIZE and selects the stored quotient or remainder. data_valid_o at N+2.
- Not defined: no storage; every request follows the normal or fast path as above.

Test Plan:
- DIVU 100/7 accepted at N -> data_valid_o=1 only at N+35, result_o=14; REMU 100/7 -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD; REM -> 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+2; REM -> 0 at N+2; DIVU 5/0 -> 0xFFFFFFFF at N+2; REM 5/0 -> 5.
- DIVU 100/7 accepted at N, flush_i pulse at N+10 -> no data_valid_o, idle_o=1 at N+11. REMU 9/4 accepted at N+11 -> 1 at N+46.
- Back-to-back: second request held high, accepted at N+35 (same cycle as first pulse) -> second data_valid_o at N+70. Async reset asserted at N+20 -> outputs 0 immediately, no pulse.
- DIV 100/7 then REM 100/7: with DIV_RESULT_FORWARD_EN, REM returns 2 two cycles after accept; without it, 35 cycles. DIVU 100/7 after DIV 100/7 -> full 35-cycle latency (signedness mismatch).
